// File: rtl/dica_bits_corretos_n.sv
// Clocked "correct bits" hint for the bomb puzzle: serially counts matching bits of each
// confirmed guess, shows the count as a thermometer and walks through ETAPAS passwords.
module dica_bits_corretos_n #(
  parameter int LARGURA  = 4,
  parameter int ETAPAS   = 2,
  parameter int MAX_TENT = 8
) (
  input  logic                              CLOCK_50,
  input  logic                              RESET,
  input  logic                              ENABLE,
  input  logic                              ENTER,
  input  logic [LARGURA-1:0]                TENTATIVA,
  input  logic [ETAPAS*LARGURA-1:0]         SENHAS,
  output logic [LARGURA-1:0]                LEDR,
  output logic [$clog2(ETAPAS+1)-1:0]       ETAPA,
  output logic [$clog2(MAX_TENT+1)-1:0]     TENT_RESTANTES,
  output logic                              OCUPADO,
  output logic                              ACERTOU,
  output logic                              CONCLUIDO,
  output logic                              ESGOTADO
);

  // state    | meaning
  // OCIOSO   | waiting for a synchronised ENTER edge
  // CONTANDO | comparing one bit per clock
  // AVALIA   | publishing the count, advancing stage or spending an attempt
  // FIM      | game solved or attempts exhausted; only RESET leaves
  localparam logic [1:0] OCIOSO   = 2'd0;
  localparam logic [1:0] CONTANDO = 2'd1;
  localparam logic [1:0] AVALIA   = 2'd2;
  localparam logic [1:0] FIM      = 2'd3;

  localparam int EW = $clog2(ETAPAS + 1);
  localparam int TW = $clog2(MAX_TENT + 1);
  localparam int CW = $clog2(LARGURA + 1);
  localparam int IW = (LARGURA > 1) ? $clog2(LARGURA) : 1;

  logic [1:0]         estado;
  logic               enter_s1, enter_s2, enter_prev;
  logic               enter_edge;
  logic [LARGURA-1:0] tentativa_r, senha_r, senha_atual;
  logic [CW-1:0]      acc, bits_corretos;
  logic [IW-1:0]      idx;

  assign enter_edge = enter_s2 && !enter_prev;
  assign OCUPADO    = (estado == CONTANDO) || (estado == AVALIA);

  // ETAPA only reaches ETAPAS in FIM, where the selected password is unused
  always_comb begin
    senha_atual = '0;
    for (int k = 0; k < ETAPAS; k++) begin
      if (ETAPA == EW'(k)) senha_atual = SENHAS[k*LARGURA +: LARGURA];
    end
  end

  always_comb begin
    LEDR = '0;
    for (int i = 0; i < LARGURA; i++) begin
      LEDR[i] = ENABLE && (bits_corretos > CW'(i));
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      estado         <= OCIOSO;
      enter_s1       <= 1'b0;
      enter_s2       <= 1'b0;
      enter_prev     <= 1'b0;
      tentativa_r    <= '0;
      senha_r        <= '0;
      acc            <= '0;
      idx            <= '0;
      bits_corretos  <= '0;
      ETAPA          <= '0;
      TENT_RESTANTES <= TW'(MAX_TENT);
      ACERTOU        <= 1'b0;
      CONCLUIDO      <= 1'b0;
      ESGOTADO       <= 1'b0;
    end else begin
      enter_s1   <= ENTER;
      enter_s2   <= enter_s1;
      enter_prev <= enter_s2;
      ACERTOU    <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (enter_edge) begin
            tentativa_r <= TENTATIVA;
            senha_r     <= senha_atual;
            acc         <= '0;
            idx         <= '0;
            estado      <= CONTANDO;
          end
        end
        CONTANDO: begin
          acc <= acc + CW'(tentativa_r[idx] ~^ senha_r[idx]);
          idx <= idx + IW'(1);
          if (idx == IW'(LARGURA - 1)) estado <= AVALIA;
        end
        AVALIA: begin
          bits_corretos <= acc;
          if (acc == CW'(LARGURA)) begin
            ACERTOU        <= 1'b1;
            ETAPA          <= ETAPA + EW'(1);
            TENT_RESTANTES <= TW'(MAX_TENT);
            if (ETAPA == EW'(ETAPAS - 1)) begin
              CONCLUIDO <= 1'b1;
              estado    <= FIM;
            end else begin
              estado <= OCIOSO;
            end
          end else begin
            TENT_RESTANTES <= TENT_RESTANTES - TW'(1);
            if (TENT_RESTANTES == TW'(1)) begin
              ESGOTADO <= 1'b1;
              estado   <= FIM;
            end else begin
              estado <= OCIOSO;
            end
          end
        end
        FIM:     estado <= FIM;
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: doc/dica_bits_corretos_n.md
# dica_bits_corretos_n

Parametrised, clocked successor of the "correct bits" hint block for the bomb puzzle. For each confirmed guess it counts, one bit per clock, how many bits of `TENTATIVA` match the current stage's password. It shows the count as a thermometer on the LEDs, advances through `ETAPAS` passwords on exact matches, and enforces a per-stage attempt limit. It sits between the switch/key inputs and the LEDR bank, and feeds stage and game-over status to the top-level game controller.

## Interface
- `LARGURA`, default 4: password and guess width W, in bits (≥1).
- `ETAPAS`, default 2: number of sequential passwords N (≥1).
- `MAX_TENT`, default 8: wrong attempts allowed per stage (≥1).
- `CLOCK_50`  in  1  system clock; the only clock.
- `RESET`  in  1  asynchronous, active-high reset.
- `ENABLE`  in  1  LED display enable; does not gate the state machine.
- `ENTER`  in  1  confirm key, asynchronous level, active-high; synchronised internally.
- `TENTATIVA`  in  W  guess from the switches.
- `SENHAS`  in  N*W  passwords; stage k is `SENHAS[k*W +: W]`.
- `LEDR`  out  W  thermometer of the last correct-bit count.
- `ETAPA`  out  $clog2(N+1)  current stage, 0..N.
- `TENT_RESTANTES`  out  $clog2(MAX_TENT+1)  attempts left in the current stage.
- `OCUPADO`  out  1  high while an evaluation is in progress.
- `ACERTOU`  out  1  one-cycle pulse on an exact match.
- `CONCLUIDO`  out  1  sticky; all N stages solved.
- `ESGOTADO`  out  1  sticky; attempts exhausted.

## Operation
- **Reset values:** all outputs and internal registers are 0, except `TENT_RESTANTES = MAX_TENT`. State is OCIOSO.
- **ENTER capture:** `ENTER` passes through a 2-flop synchroniser plus an edge register. Cycle E is the first clock at which the synchronised value is 1 and the previous value was 0.
- **States:** OCIOSO, CONTANDO, AVALIA, FIM.
- **OCIOSO:** on edge E, latch `TENTATIVA` and `SENHAS[ETAPA]`, clear the accumulator and bit index, then go to CONTANDO. Other cycles: hold.
- **CONTANDO:** each cycle, accumulator += (guess[idx] XNOR pass[idx]) and idx++. After idx = W-1, go to AVALIA. Exactly W cycles are spent here.
- **AVALIA:** one cycle.
  - Copy the accumulator into `bits_corretos`.
  - If accumulator == W: pulse `ACERTOU`, `ETAPA`++, reload `TENT_RESTANTES = MAX_TENT`. If the new `ETAPA` == N, set `CONCLUIDO` and go to FIM; otherwise go to OCIOSO.
  - Otherwise: `TENT_RESTANTES`--. If it reaches 0, set `ESGOTADO` and go to FIM; otherwise go to OCIOSO.
- **FIM:** absorbing state; all ENTER edges are ignored. Only `RESET` leaves it.
- **Widths:** the accumulator and `bits_corretos` are $clog2(W+1) bits, so the count never wraps. The bit index is $clog2(W) bits (1 bit when W = 1).
- **LEDR:** `LEDR[i] = ENABLE && (i < bits_corretos)`, combinational from registers. When `ENABLE` = 0, `LEDR` is all zeros and the count is retained.
- **OCUPADO:** 1 in CONTANDO and AVALIA.
- **Ignored input changes:**
  - ENTER edges while CONTANDO or AVALIA are dropped, not queued.
  - Changes to `TENTATIVA` or `SENHAS` after E do not affect the evaluation in progress.
- **RESET mid-evaluation:** abort immediately to the reset values. No `ACERTOU` pulse and no change to the attempt count.

## Timing
- Edge E is detected 2–3 clocks after `ENTER` rises, depending on metastability margin.
- E to state CONTANDO: registered at clock E.
- `OCUPADO` is high for cycles E+1 .. E+W+1 (W+1 cycles).
- `bits_corretos`, `LEDR`, `ETAPA`, `TENT_RESTANTES`, `CONCLUIDO` and `ESGOTADO` update at the clock ending AVALIA, so they are visible from cycle E+W+2.
- `ACERTOU` is high for exactly cycle E+W+2.
- A new edge is accepted from cycle E+W+2 onward.
- Throughput is at most one guess per W+2 clocks.

## Test plan
Bench parameters: W = 4, N = 2, MAX_TENT = 3, stage 0 password = 1010, stage 1 password = 0101, `ENABLE` = 1.
- **Partial match:** after reset, `TENTATIVA` = 1000 and ENTER pulsed → `OCUPADO` high for 5 cycles, then `LEDR` = 0111, `TENT_RESTANTES` = 2, `ETAPA` = 0, no `ACERTOU`.
- **Stage advance:** `TENTATIVA` = 1010 → `LEDR` = 1111, `ACERTOU` high for 1 cycle, `ETAPA` = 1, `TENT_RESTANTES` = 3.
- **Completion:** then `TENTATIVA` = 0101 → `ETAPA` = 2, `CONCLUIDO` = 1. Further ENTER with 0000 leaves `LEDR` = 1111 and all status unchanged.
- **Exhaustion:** from reset, three guesses of 0101 (0 matches) → `LEDR` = 0000, `TENT_RESTANTES` 2→1→0, `ESGOTADO` = 1. A fourth ENTER is ignored.
- **Ignored ENTER and mid-count reset:**
  - A second ENTER edge while `OCUPADO` = 1 leaves `TENT_RESTANTES` decremented once only.
  - `RESET` asserted in the 2nd CONTANDO cycle → all outputs return to reset values with `TENT_RESTANTES` = 3.
- **Display gating:** after a 3-match result, `ENABLE` = 0 → `LEDR` = 0000. `ENABLE` back to 1 → `LEDR` = 0111 with no new ENTER.
